gold_seq_gen: RTL

- Parametrised two-register Gold/PN chip generator for the spreading path.
- Replaces fixed-length, fixed-tap delay-line generators with:
  - runtime tap masks and parallel seed load;
  - a Start/Stop run state machine;
  - epoch (period) marking;
  - per-register serial fill override;
  - all-zero lockup detection.
- Sits between the code-control register block and the spreader; one chip per enabled cycle.

---
 rtl/gold_seq_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gold_seq_gen.sv
// ---------------------------------------------------------------------------
// gold_seq_gen
//
// Two-register Gold / PN chip generator for the spreading path. Registers A
// and B are Fibonacci LFSRs with runtime tap masks. The Gold chip is the XOR
// of their MSBs. The block sits between the code-control register block and
// the spreader and produces one chip per enabled cycle while in RUN.
//
// Ports
//   Clock       in   rising-edge clock
//   Reset_n     in   asynchronous active-low reset
//   Enable      in   advance one chip this cycle (RUN only)
//   Start       in   pulse: load seeds and enter RUN (restart when in RUN)
//   Stop        in   pulse: return to IDLE (wins over Start)
//   Taps_A/B    in   feedback masks, LEN bits each
//   Seed_A/B    in   parallel initial fills, LEN bits each
//   Fill_En_A/B in   replace the register's feedback bit with Fill_Bit
//   Fill_Bit    in   serial fill data
//   Chip_Out    out  MSB(A) ^ MSB(B) while Chip_Valid, else 0
//   Chip_Valid  out  high while in RUN
//   Epoch       out  marks the last chip of the period (combinational)
//   Chip_Cnt    out  index of the current chip within the epoch
//   Seed_Err    out  one-cycle pulse: a Start was rejected (zero seed)
//   Lock_Err    out  sticky: a register reached all-zero while running
//   Dbg_State   out  current run-state (0 = IDLE, 1 = RUN)
//
// Handshake: Chip_Valid/Chip_Out form a valid-only stream; there is no
// ready. The consumer takes the current chip on every edge where
// Chip_Valid & Enable are high, because that edge advances to the next chip.
// While Enable is low the chip is held and must not be counted again.
// ---------------------------------------------------------------------------
module gold_seq_gen #(
    parameter int LEN    = 10,
    parameter int PERIOD = 1023,
    parameter int CNT_W  = 10
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic             Start,
    input  logic             Stop,
    input  logic [LEN-1:0]   Taps_A,
    input  logic [LEN-1:0]   Taps_B,
    input  logic [LEN-1:0]   Seed_A,
    input  logic [LEN-1:0]   Seed_B,
    input  logic             Fill_En_A,
    input  logic             Fill_En_B,
    input  logic             Fill_Bit,
    output logic             Chip_Out,
    output logic             Chip_Valid,
    output logic             Epoch,
    output logic [CNT_W-1:0] Chip_Cnt,
    output logic             Seed_Err,
    output logic             Lock_Err,
    output logic             Dbg_State
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LEN-1:0]   REG_ZERO = '0;

    state_t           state_q,    state_d;
    logic [LEN-1:0]   reg_a_q,    reg_a_d;
    logic [LEN-1:0]   reg_b_q,    reg_b_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             seed_err_q, seed_err_d;
    logic             lock_err_q, lock_err_d;

    // Per-register feedback and shifted value, used only when advancing.
    logic             fb_a;
    logic             fb_b;
    logic [LEN-1:0]   shift_a;
    logic [LEN-1:0]   shift_b;
    logic             seeds_ok;
    logic             running;

    always_comb begin
        fb_a     = Fill_En_A ? Fill_Bit : ^(reg_a_q & Taps_A);
        fb_b     = Fill_En_B ? Fill_Bit : ^(reg_b_q & Taps_B);
        shift_a  = {reg_a_q[LEN-2:0], fb_a};
        shift_b  = {reg_b_q[LEN-2:0], fb_b};
        seeds_ok = (Seed_A != REG_ZERO) && (Seed_B != REG_ZERO);
        running  = (state_q == ST_RUN);
    end

    // Next-state / register update. Priority: Stop, then Start, then advance.
    // A rejected Start (zero seed) leaves every register untouched, including
    // in RUN, where it also suppresses that cycle's advance.
    always_comb begin
        state_d    = state_q;
        reg_a_d    = reg_a_q;
        reg_b_d    = reg_b_q;
        cnt_d      = cnt_q;
        seed_err_d = 1'b0;
        lock_err_d = lock_err_q;

        if (Stop) begin
            state_d = ST_IDLE;
        end else if (Start) begin
            if (seeds_ok) begin
                state_d    = ST_RUN;
                reg_a_d    = Seed_A;
                reg_b_d    = Seed_B;
                cnt_d      = '0;
                lock_err_d = 1'b0;
            end else begin
                seed_err_d = 1'b1;
            end
        end else if (running && Enable) begin
            reg_a_d = shift_a;
            reg_b_d = shift_b;
            cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
            // An all-zero register can never leave zero through its own
            // feedback, so stop the run as soon as an update produces one.
            if ((shift_a == REG_ZERO) || (shift_b == REG_ZERO)) begin
                lock_err_d = 1'b1;
                state_d    = ST_IDLE;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            cnt_q      <= '0;
            seed_err_q <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_a_q    <= reg_a_d;
            reg_b_q    <= reg_b_d;
            cnt_q      <= cnt_d;
            seed_err_q <= seed_err_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Outputs are derived from registers only (plus Enable for Epoch), so a
    // reset drives them all low without waiting for a clock edge.
    always_comb begin
        Chip_Valid = running;
        Chip_Out   = running & (reg_a_q[LEN-1] ^ reg_b_q[LEN-1]);
        Epoch      = running & Enable & (cnt_q == CNT_LAST);
        Chip_Cnt   = cnt_q;
        Seed_Err   = seed_err_q;
        Lock_Err   = lock_err_q;
        Dbg_State  = state_q;
    end

endmodule
